// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Sequential fetch/issue front end. Holds the PC, issues one word-aligned
// request at a time to instruction memory, latches the returned word into an
// issue register and presents its RV32 fields to the control unit until the
// consumer accepts them. Branch redirects retarget the PC and discard any
// stale in-flight or held instruction. Fetching stops once an instruction
// whose opcode equals HALT_OPCODE is issued; `start` resumes at RESET_PC.
//
// Optional feature macro: FETCH_STATS_EN
//   defined   : fetch_count / discard_count are live 32-bit wrapping counters
//   undefined : both count ports are tied to 0 and no counter flops exist
//
// Parameters
//   RESET_PC     first fetch address after start
//   HALT_OPCODE  opcode that stops fetching once issued
//
// Ports
//   clk, rst                     clock, async active-high reset
//   start                        level, sampled only in IDLE
//   imem_req_valid/addr/ready    fetch request handshake
//   imem_resp_valid/data         fetch response (no backpressure)
//   dec_valid/ready              issue handshake
//   dec_opcode..dec_funct7       RV32 fields of the issued word
//   dec_pc                       address of the issued word
//   redirect_valid/pc            one-cycle branch/jump redirect
//   busy                         high whenever not IDLE
//   fetch_count, discard_count   statistics (see macro above)
//
// All outputs come straight from flops; there is no input-to-output path.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [6:0]  HALT_OPCODE = 7'b1110011
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [6:0]  dec_opcode,
   output logic [4:0]  dec_rd,
   output logic [2:0]  dec_funct3,
   output logic [4:0]  dec_rs1,
   output logic [4:0]  dec_rs2,
   output logic [6:0]  dec_funct7,
   output logic [31:0] dec_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        busy,
   output logic [31:0] fetch_count,
   output logic [31:0] discard_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   // RV32 base field layout, MSB first, so a raw word casts straight in.
   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } rv_fields_t;

   state_t     state;
   logic [31:0] pc;
   logic        drop;      // the outstanding response is stale
   rv_fields_t  ir;        // issue register

   logic [31:0] redir_pc;
   logic [31:0] pc_inc;
   logic        issue_hs;

   assign redir_pc = redirect_pc & ~32'h3;
   assign pc_inc   = pc + 32'd4;
   // dec_valid is high for the whole of HOLD, so ready alone completes it.
   assign issue_hs = (state == HOLD) && dec_ready;

   assign dec_opcode = ir.opcode;
   assign dec_rd     = ir.rd;
   assign dec_funct3 = ir.funct3;
   assign dec_rs1    = ir.rs1;
   assign dec_rs2    = ir.rs2;
   assign dec_funct7 = ir.funct7;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         pc             <= RESET_PC;
         drop           <= 1'b0;
         ir             <= '0;
         dec_pc         <= '0;
         dec_valid      <= 1'b0;
         imem_req_valid <= 1'b0;
         imem_req_addr  <= '0;
         busy           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  pc             <= RESET_PC;
                  imem_req_addr  <= RESET_PC;
                  imem_req_valid <= 1'b1;
                  busy           <= 1'b1;
                  state          <= REQ;
               end
            end

            REQ: begin
               if (redirect_valid) begin
                  pc <= redir_pc;
                  if (imem_req_ready) begin
                     // The old address went out this cycle; its word is stale.
                     imem_req_valid <= 1'b0;
                     drop           <= 1'b1;
                     state          <= WAIT;
                  end else begin
                     imem_req_addr <= redir_pc;
                  end
               end else if (imem_req_ready) begin
                  imem_req_valid <= 1'b0;
                  state          <= WAIT;
               end
            end

            WAIT: begin
               if (redirect_valid) begin
                  pc <= redir_pc;
                  if (imem_resp_valid) begin
                     // Response arriving alongside the redirect is stale.
                     drop           <= 1'b0;
                     imem_req_addr  <= redir_pc;
                     imem_req_valid <= 1'b1;
                     state          <= REQ;
                  end else begin
                     drop <= 1'b1;
                  end
               end else if (imem_resp_valid) begin
                  if (drop) begin
                     drop           <= 1'b0;
                     imem_req_addr  <= pc;
                     imem_req_valid <= 1'b1;
                     state          <= REQ;
                  end else begin
                     ir        <= rv_fields_t'(imem_resp_data);
                     dec_pc    <= pc;
                     dec_valid <= 1'b1;
                     state     <= HOLD;
                  end
               end
            end

            HOLD: begin
               if (redirect_valid) begin
                  // Redirect wins over both pc+4 and halt.
                  pc             <= redir_pc;
                  imem_req_addr  <= redir_pc;
                  imem_req_valid <= 1'b1;
                  dec_valid      <= 1'b0;
                  state          <= REQ;
               end else if (dec_ready) begin
                  pc        <= pc_inc;
                  dec_valid <= 1'b0;
                  if (ir.opcode == HALT_OPCODE) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     imem_req_addr  <= pc_inc;
                     imem_req_valid <= 1'b1;
                     state          <= REQ;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

`ifdef FETCH_STATS_EN
   // Dropped work: a stale response in WAIT, or a held instruction that a
   // redirect kills before the consumer takes it.
   logic drop_evt;
   assign drop_evt = ((state == WAIT) && imem_resp_valid && (drop || redirect_valid)) ||
                     ((state == HOLD) && redirect_valid && !dec_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count   <= '0;
         discard_count <= '0;
      end else begin
         if (issue_hs) fetch_count   <= fetch_count + 32'd1;
         if (drop_evt) discard_count <= discard_count + 32'd1;
      end
   end
`else
   assign fetch_count   = '0;
   assign discard_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        dec_valid;
   logic        dec_ready;
   logic [6:0]  dec_opcode;
   logic [4:0]  dec_rd;
   logic [2:0]  dec_funct3;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [6:0]  dec_funct7;
   logic [31:0] dec_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy;
   logic [31:0] fetch_count;
   logic [31:0] discard_count;

`ifdef FETCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   instr_fetch_unit dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_funct3(dec_funct3),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_funct7(dec_funct7),
      .dec_pc(dec_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .busy(busy), .fetch_count(fetch_count), .discard_count(discard_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  f7;
      int          delay;   // response latency beyond the minimum
   } vec_t;

   vec_t vecs[4];
   int   checks = 0;
   int   errors = 0;
   int   exp_fetch = 0;
   int   exp_disc  = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, " fetch_count"}, fetch_count, STATS ? exp_fetch : 0);
      chk({tag, " discard_count"}, discard_count, STATS ? exp_disc : 0);
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!imem_req_valid && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (!imem_req_valid) begin
         errors++;
         $display("FAIL %s no imem_req_valid within 20 cycles got=0 expected=1", name);
      end
   endtask

   // Request at exp_pc, accept it, answer after `delay` extra cycles, land in HOLD.
   task automatic to_hold(input string name, input logic [31:0] word,
                          input logic [31:0] exp_pc, input int delay);
      wait_req(name);
      chk({name, " req_addr"}, imem_req_addr, exp_pc);
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      chk({name, " req_valid after accept"}, imem_req_valid, 0);
      for (int i = 0; i < delay; i++) step();
      imem_resp_valid = 1'b1;
      imem_resp_data  = word;
      step();
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'hDEAD_BEEF;
      chk({name, " dec_valid"}, dec_valid, 1);
      chk({name, " dec_pc"}, dec_pc, exp_pc);
   endtask

   task automatic issue();
      dec_ready = 1'b1;
      step();
      dec_ready = 1'b0;
      exp_fetch++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //                instr          op        rd  f3  rs1 rs2 f7       delay
      vecs[0] = '{32'h0020_81B3, 7'h33, 5'd3,  3'd0, 5'd1,  5'd2,  7'h00, 0};
      vecs[1] = '{32'h4050_8233, 7'h33, 5'd4,  3'd0, 5'd1,  5'd5,  7'h20, 1};
      vecs[2] = '{32'hFFFF_FF93, 7'h13, 5'd31, 3'd7, 5'd31, 5'd31, 7'h7F, 2};
      vecs[3] = '{32'h02AA_58B3, 7'h33, 5'd17, 3'd5, 5'd20, 5'd10, 7'h01, 0};

      rst = 1'b1; start = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
      imem_resp_data = '0; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

      // Reset state
      #3;
      chk("reset req_valid", imem_req_valid, 0);
      chk("reset req_addr", imem_req_addr, 0);
      chk("reset dec_valid", dec_valid, 0);
      chk("reset busy", busy, 0);
      chk("reset dec_pc", dec_pc, 0);
      chk("reset dec_fields", {dec_funct7, dec_rs2, dec_rs1, dec_funct3, dec_rd, dec_opcode}, 0);
      chk_counts("reset");
      step(); step();
      rst = 1'b0;
      step();
      // Responses in IDLE are ignored
      imem_resp_valid = 1'b1;
      step();
      imem_resp_valid = 1'b0;
      chk("idle resp dec_valid", dec_valid, 0);
      chk("idle req_valid", imem_req_valid, 0);

      // Start: request visible the cycle after start is sampled
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start req_valid", imem_req_valid, 1);
      chk("start busy", busy, 1);

      // Table-driven sequential fetches
      for (int i = 0; i < 4; i++) begin
         to_hold($sformatf("vec%0d", i), vecs[i].instr, 32'(i * 4), vecs[i].delay);
         chk($sformatf("vec%0d opcode", i), dec_opcode, vecs[i].op);
         chk($sformatf("vec%0d rd", i), dec_rd, vecs[i].rd);
         chk($sformatf("vec%0d funct3", i), dec_funct3, vecs[i].f3);
         chk($sformatf("vec%0d rs1", i), dec_rs1, vecs[i].rs1);
         chk($sformatf("vec%0d rs2", i), dec_rs2, vecs[i].rs2);
         chk($sformatf("vec%0d funct7", i), dec_funct7, vecs[i].f7);
         issue();
         chk($sformatf("vec%0d next req_valid", i), imem_req_valid, 1);
         chk($sformatf("vec%0d next req_addr", i), imem_req_addr, 32'(i * 4 + 4));
         chk($sformatf("vec%0d dec_valid drop", i), dec_valid, 0);
      end
      chk_counts("table");

      // Backpressure: fields held, no new request for 5 cycles
      to_hold("bp", 32'h4050_8233, 32'd16, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp dec_valid", dec_valid, 1);
         chk("bp fields", {dec_funct7, dec_rs2, dec_rs1, dec_funct3, dec_rd, dec_opcode}, 32'h4050_8233);
         chk("bp dec_pc", dec_pc, 32'd16);
         chk("bp req_valid", imem_req_valid, 0);
      end
      issue();
      chk("bp release dec_valid", dec_valid, 0);
      chk("bp release req_addr", imem_req_addr, 32'd20);
      chk_counts("bp");

      // Redirect while waiting: stale word dropped, low bits cleared
      wait_req("rw");
      chk("rw req_addr", imem_req_addr, 32'd20);
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h103;
      step();
      redirect_valid = 1'b0;
      chk("rw still waiting", imem_req_valid, 0);
      imem_resp_valid = 1'b1; imem_resp_data = 32'h0020_81B3;
      step();
      imem_resp_valid = 1'b0;
      exp_disc++;
      chk("rw dec_valid", dec_valid, 0);
      chk("rw req_valid", imem_req_valid, 1);
      chk("rw req_addr", imem_req_addr, 32'h100);
      chk_counts("rw");

      // Redirect in REQ without handshake: address retargets
      redirect_valid = 1'b1; redirect_pc = 32'h151;
      step();
      redirect_valid = 1'b0;
      chk("rq req_valid", imem_req_valid, 1);
      chk("rq req_addr", imem_req_addr, 32'h150);

      // Redirect with simultaneous issue in HOLD
      to_hold("rh", 32'h02AA_58B3, 32'h150, 0);
      dec_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
      step();
      dec_ready = 1'b0; redirect_valid = 1'b0;
      exp_fetch++;
      chk("rh req_addr", imem_req_addr, 32'h200);
      chk("rh dec_valid", dec_valid, 0);
      chk_counts("rh");

      // Redirect in HOLD without issue: held instruction dropped
      to_hold("rd", 32'h0020_81B3, 32'h200, 0);
      redirect_valid = 1'b1; redirect_pc = 32'h300;
      step();
      redirect_valid = 1'b0;
      exp_disc++;
      chk("rd dec_valid", dec_valid, 0);
      chk("rd req_addr", imem_req_addr, 32'h300);
      chk_counts("rd");

      // Halt
      to_hold("halt", 32'h0000_0073, 32'h300, 0);
      chk("halt opcode", dec_opcode, 7'h73);
      issue();
      chk("halt busy", busy, 0);
      for (int i = 0; i < 3; i++) begin
         chk("halt req_valid", imem_req_valid, 0);
         step();
      end
      chk_counts("halt");

      // Restart; redirect coincident with request handshake
      start = 1'b1;
      step();
      start = 1'b0;
      chk("rs req_addr", imem_req_addr, 32'h0);
      imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h400;
      step();
      imem_req_ready = 1'b0; redirect_valid = 1'b0;
      chk("rs waiting", imem_req_valid, 0);
      imem_resp_valid = 1'b1;
      step();
      imem_resp_valid = 1'b0;
      exp_disc++;
      chk("rs dec_valid", dec_valid, 0);
      chk("rs req_addr 400", imem_req_addr, 32'h400);
      chk_counts("rs");

      // Async reset while waiting
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("ar req_valid", imem_req_valid, 0);
      chk("ar busy", busy, 0);
      chk("ar req_addr", imem_req_addr, 0);
      chk("ar dec_pc", dec_pc, 0);
      exp_fetch = 0; exp_disc = 0;
      chk_counts("ar");
      #2;
      rst = 1'b0;
      imem_resp_valid = 1'b1; imem_resp_data = 32'h0020_81B3;
      step();
      imem_resp_valid = 1'b0;
      step();
      chk("ar late resp dec_valid", dec_valid, 0);
      chk("ar late resp busy", busy, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("ar restart req_valid", imem_req_valid, 1);
      chk("ar restart req_addr", imem_req_addr, 32'h0);
      to_hold("ar fetch", 32'h0020_81B3, 32'h0, 0);
      chk("ar fetch rd", dec_rd, 5'd3);
      issue();
      chk_counts("ar fetch");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
